// File: rtl/log_trig_pkg.sv
// Shared widths, constants and FSM state type for the log-domain trig harmonic sequencer.
package log_trig_pkg;

  localparam int unsigned PHASE_W = 6;
  localparam int unsigned LOG_W   = 16;
  localparam int unsigned K_W     = 3;

  // Log-domain stand-in for a magnitude of exactly zero.
  localparam logic [LOG_W-1:0] LOG_NEG_INF = 16'h8000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/log_trig_fold.sv
// Quadrant folding of a quarter-wave log-sin/log-cos LUT pair into full-circle sin and cos.
// Optional feature macro: LOGTRIG_ZERO_FLAG_EN (explicit zero flags instead of LOG_NEG_INF).
module log_trig_fold
  import log_trig_pkg::*;
(
  input  logic [1:0]       i_q,
  input  logic [3:0]       i_r,
  input  logic [LOG_W-1:0] i_lut_logsin,
  input  logic [LOG_W-1:0] i_lut_logcos,
  output logic [LOG_W-1:0] o_sin_log,
  output logic             o_sin_neg,
  output logic             o_sin_zero,
  output logic [LOG_W-1:0] o_cos_log,
  output logic             o_cos_neg,
  output logic             o_cos_zero
);

  logic [LOG_W-1:0] w_sin_mag;
  logic [LOG_W-1:0] w_cos_mag;
  logic             w_sin_sgn;
  logic             w_cos_sgn;
  logic             w_sin_zc;
  logic             w_cos_zc;

  // Select magnitude source and sign per quadrant; a zero magnitude never carries a sign.
  always_comb begin
    w_sin_mag = i_lut_logsin;
    w_cos_mag = i_lut_logcos;
    w_sin_sgn = 1'b0;
    w_cos_sgn = 1'b0;
    w_sin_zc  = (i_r == 4'd0) && !i_q[0];
    w_cos_zc  = (i_r == 4'd0) && i_q[0];
    unique case (i_q)
      2'd0: begin
        w_sin_mag = i_lut_logsin;  w_sin_sgn = 1'b0;
        w_cos_mag = i_lut_logcos;  w_cos_sgn = 1'b0;
      end
      2'd1: begin
        w_sin_mag = i_lut_logcos;  w_sin_sgn = 1'b0;
        w_cos_mag = i_lut_logsin;  w_cos_sgn = 1'b1;
      end
      2'd2: begin
        w_sin_mag = i_lut_logsin;  w_sin_sgn = 1'b1;
        w_cos_mag = i_lut_logcos;  w_cos_sgn = 1'b1;
      end
      default: begin
        w_sin_mag = i_lut_logcos;  w_sin_sgn = 1'b1;
        w_cos_mag = i_lut_logsin;  w_cos_sgn = 1'b0;
      end
    endcase
    o_sin_neg = w_sin_sgn && !w_sin_zc;
    o_cos_neg = w_cos_sgn && !w_cos_zc;
`ifdef LOGTRIG_ZERO_FLAG_EN
    o_sin_log  = w_sin_mag;
    o_cos_log  = w_cos_mag;
    o_sin_zero = w_sin_zc;
    o_cos_zero = w_cos_zc;
`else
    o_sin_log  = w_sin_zc ? LOG_NEG_INF : w_sin_mag;
    o_cos_log  = w_cos_zc ? LOG_NEG_INF : w_cos_mag;
    o_sin_zero = 1'b0;
    o_cos_zero = 1'b0;
`endif
  end

endmodule

// File: rtl/log_trig_expansion_seq.sv
// Harmonic sequencer: for each accepted phase, emits log|sin(k*theta)| and log|cos(k*theta)|
// for k = 1..ORDER, forming k*theta by repeated addition. Optional macro: LOGTRIG_ZERO_FLAG_EN.
module log_trig_expansion_seq
  import log_trig_pkg::*;
#(
  parameter int unsigned ORDER = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PHASE_W-1:0] in_phase,
  output logic [4:0]         lut_idx,
  input  logic [LOG_W-1:0]   lut_logsin,
  input  logic [LOG_W-1:0]   lut_logcos,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LOG_W-1:0]   out_logsin,
  output logic [LOG_W-1:0]   out_logcos,
  output logic               out_sin_neg,
  output logic               out_cos_neg,
  output logic               out_sin_zero,
  output logic               out_cos_zero,
  output logic [K_W-1:0]     out_k,
  output logic               out_last
);

  localparam logic [K_W-1:0] OrderK = K_W'(ORDER);

  state_t             r_state;
  logic [PHASE_W-1:0] r_base;
  logic [PHASE_W-1:0] r_acc;
  logic [K_W-1:0]     r_k;
  logic               r_out_valid;
  logic [LOG_W-1:0]   r_out_logsin;
  logic [LOG_W-1:0]   r_out_logcos;
  logic               r_out_sin_neg;
  logic               r_out_cos_neg;
  logic               r_out_sin_zero;
  logic               r_out_cos_zero;
  logic [K_W-1:0]     r_out_k;
  logic               r_out_last;

  logic               w_advance;
  logic [LOG_W-1:0]   w_sin_log;
  logic [LOG_W-1:0]   w_cos_log;
  logic               w_sin_neg;
  logic               w_cos_neg;
  logic               w_sin_zero;
  logic               w_cos_zero;

  assign w_advance = (r_state == RUN) && (!r_out_valid || out_ready);
  assign in_ready  = (r_state == IDLE);
  assign lut_idx   = {1'b0, r_acc[3:0]};

  log_trig_fold u_fold (
    .i_q          (r_acc[5:4]),
    .i_r          (r_acc[3:0]),
    .i_lut_logsin (lut_logsin),
    .i_lut_logcos (lut_logcos),
    .o_sin_log    (w_sin_log),
    .o_sin_neg    (w_sin_neg),
    .o_sin_zero   (w_sin_zero),
    .o_cos_log    (w_cos_log),
    .o_cos_neg    (w_cos_neg),
    .o_cos_zero   (w_cos_zero)
  );

  // Sequencer FSM: capture a phase in IDLE, then step the angle accumulator once per advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_base         <= '0;
      r_acc          <= '0;
      r_k            <= '0;
      r_out_valid    <= 1'b0;
      r_out_logsin   <= '0;
      r_out_logcos   <= '0;
      r_out_sin_neg  <= 1'b0;
      r_out_cos_neg  <= 1'b0;
      r_out_sin_zero <= 1'b0;
      r_out_cos_zero <= 1'b0;
      r_out_k        <= '0;
      r_out_last     <= 1'b0;
    end else begin
      // Result consumed and nothing new to replace it.
      if (out_ready && !w_advance) begin
        r_out_valid <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_base  <= in_phase;
            r_acc   <= in_phase;
            r_k     <= K_W'(1);
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_advance) begin
            r_out_valid    <= 1'b1;
            r_out_logsin   <= w_sin_log;
            r_out_logcos   <= w_cos_log;
            r_out_sin_neg  <= w_sin_neg;
            r_out_cos_neg  <= w_cos_neg;
            r_out_sin_zero <= w_sin_zero;
            r_out_cos_zero <= w_cos_zero;
            r_out_k        <= r_k;
            r_out_last     <= (r_k == OrderK);
            r_acc          <= r_acc + r_base;  // mod-64 wrap is the intended angle wrap
            r_k            <= r_k + K_W'(1);
            if (r_k == OrderK) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid    = r_out_valid;
  assign out_logsin   = r_out_logsin;
  assign out_logcos   = r_out_logcos;
  assign out_sin_neg  = r_out_sin_neg;
  assign out_cos_neg  = r_out_cos_neg;
  assign out_sin_zero = r_out_sin_zero;
  assign out_cos_zero = r_out_cos_zero;
  assign out_k        = r_out_k;
  assign out_last     = r_out_last;

endmodule

// File: tb/tb_log_trig_expansion_seq.sv
// Directed bench for log_trig_expansion_seq (default build, LOGTRIG_ZERO_FLAG_EN undefined).
// The external LUT is modelled as logsin[i] = 16'hA500 | i and logcos[i] = 16'hC300 | i,
// except logcos[0] = 0 (log of 1).
module tb_log_trig_expansion_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  in_phase;
  logic [4:0]  lut_idx;
  logic [15:0] lut_logsin, lut_logcos, out_logsin, out_logcos;
  logic        out_sin_neg, out_cos_neg, out_sin_zero, out_cos_zero, out_last;
  logic [2:0]  out_k;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [5:0]  in_phase2;
  logic [4:0]  lut_idx2;
  logic [15:0] lut_logsin2, lut_logcos2, out_logsin2, out_logcos2;
  logic        out_sin_neg2, out_cos_neg2, out_sin_zero2, out_cos_zero2, out_last2;
  logic [2:0]  out_k2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign lut_logsin  = {8'hA5, 3'b000, lut_idx};
  assign lut_logcos  = (lut_idx == 5'd0) ? 16'h0000 : {8'hC3, 3'b000, lut_idx};
  assign lut_logsin2 = {8'hA5, 3'b000, lut_idx2};
  assign lut_logcos2 = (lut_idx2 == 5'd0) ? 16'h0000 : {8'hC3, 3'b000, lut_idx2};

  log_trig_expansion_seq #(.ORDER(3)) u_dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
    .in_phase (in_phase), .lut_idx (lut_idx), .lut_logsin (lut_logsin),
    .lut_logcos (lut_logcos), .out_valid (out_valid), .out_ready (out_ready),
    .out_logsin (out_logsin), .out_logcos (out_logcos), .out_sin_neg (out_sin_neg),
    .out_cos_neg (out_cos_neg), .out_sin_zero (out_sin_zero), .out_cos_zero (out_cos_zero),
    .out_k (out_k), .out_last (out_last)
  );

  log_trig_expansion_seq #(.ORDER(2)) u_dut2 (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid2), .in_ready (in_ready2),
    .in_phase (in_phase2), .lut_idx (lut_idx2), .lut_logsin (lut_logsin2),
    .lut_logcos (lut_logcos2), .out_valid (out_valid2), .out_ready (out_ready2),
    .out_logsin (out_logsin2), .out_logcos (out_logcos2), .out_sin_neg (out_sin_neg2),
    .out_cos_neg (out_cos_neg2), .out_sin_zero (out_sin_zero2), .out_cos_zero (out_cos_zero2),
    .out_k (out_k2), .out_last (out_last2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [5:0] ph);
    in_phase = ph;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_phase = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_phase2 = '0; out_ready2 = 1'b1;
    #1;
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_lut_idx", 16'(lut_idx), 16'd0);
    chk("rst_out_logsin", out_logsin, 16'h0000);
    chk("rst_out_k", 16'(out_k), 16'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // phase 5: all quadrant 0
    pulse(6'd5);
    chk("p5_idx1", 16'(lut_idx), 16'd5);
    chk("p5_in_ready_run", 16'(in_ready), 16'd0);
    chk("p5_valid_lat", 16'(out_valid), 16'd0);
    tick();
    chk("p5_k1_valid", 16'(out_valid), 16'd1);
    chk("p5_k1_k", 16'(out_k), 16'd1);
    chk("p5_k1_sin", out_logsin, 16'hA505);
    chk("p5_k1_cos", out_logcos, 16'hC305);
    chk("p5_k1_negs", {14'd0, out_sin_neg, out_cos_neg}, 16'd0);
    chk("p5_k1_last", 16'(out_last), 16'd0);
    chk("p5_idx2", 16'(lut_idx), 16'd10);
    tick();
    chk("p5_k2_k", 16'(out_k), 16'd2);
    chk("p5_k2_sin", out_logsin, 16'hA50A);
    chk("p5_k2_last", 16'(out_last), 16'd0);
    chk("p5_idx3", 16'(lut_idx), 16'd15);
    tick();
    chk("p5_k3_k", 16'(out_k), 16'd3);
    chk("p5_k3_sin", out_logsin, 16'hA50F);
    chk("p5_k3_last", 16'(out_last), 16'd1);
    chk("p5_k3_in_ready", 16'(in_ready), 16'd1);
    tick();
    chk("p5_drain_valid", 16'(out_valid), 16'd0);

    // phase 20: quadrants 1, 2, 3
    pulse(6'd20);
    tick();
    chk("p20_k1_sin", out_logsin, 16'hC304);
    chk("p20_k1_cos", out_logcos, 16'hA504);
    chk("p20_k1_negs", {14'd0, out_sin_neg, out_cos_neg}, 16'b01);
    tick();
    chk("p20_k2_sin", out_logsin, 16'hA508);
    chk("p20_k2_cos", out_logcos, 16'hC308);
    chk("p20_k2_negs", {14'd0, out_sin_neg, out_cos_neg}, 16'b11);
    tick();
    chk("p20_k3_sin", out_logsin, 16'hC30C);
    chk("p20_k3_cos", out_logcos, 16'hA50C);
    chk("p20_k3_negs", {14'd0, out_sin_neg, out_cos_neg}, 16'b10);
    tick();

    // phase 0: sin magnitude zero on every harmonic
    pulse(6'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("p0_k", 16'(out_k), 16'(k));
      chk("p0_sin_neg_inf", out_logsin, 16'h8000);
      chk("p0_cos", out_logcos, 16'h0000);
      chk("p0_zero_flags", {14'd0, out_sin_zero, out_cos_zero}, 16'd0);
      chk("p0_negs", {14'd0, out_sin_neg, out_cos_neg}, 16'd0);
    end
    tick();

    // phase 63 on the ORDER=2 instance: angle wraps to 62
    in_phase2 = 6'd63;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    chk("p63_idx1", 16'(lut_idx2), 16'd15);
    tick();
    chk("p63_k1_sin", out_logsin2, 16'hC30F);
    chk("p63_k1_sin_neg", 16'(out_sin_neg2), 16'd1);
    chk("p63_k1_last", 16'(out_last2), 16'd0);
    chk("p63_idx2_wrap", 16'(lut_idx2), 16'd14);
    tick();
    chk("p63_k2_k", 16'(out_k2), 16'd2);
    chk("p63_k2_sin", out_logsin2, 16'hC30E);
    chk("p63_k2_cos", out_logcos2, 16'hA50E);
    chk("p63_k2_cos_neg", 16'(out_cos_neg2), 16'd0);
    chk("p63_k2_last", 16'(out_last2), 16'd1);
    chk("p63_k2_in_ready", 16'(in_ready2), 16'd1);
    tick();

    // backpressure: hold k=1 for three cycles
    pulse(6'd5);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 16'(out_valid), 16'd1);
      chk("stall_k", 16'(out_k), 16'd1);
      chk("stall_sin", out_logsin, 16'hA505);
      chk("stall_idx", 16'(lut_idx), 16'd10);
      chk("stall_in_ready", 16'(in_ready), 16'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("resume_k2", 16'(out_k), 16'd2);
    chk("resume_sin2", out_logsin, 16'hA50A);
    chk("resume_in_ready2", 16'(in_ready), 16'd0);
    tick();
    chk("resume_k3", 16'(out_k), 16'd3);
    chk("resume_in_ready3", 16'(in_ready), 16'd1);
    tick();

    // asynchronous reset during k=2
    pulse(6'd20);
    tick();
    tick();
    chk("mid_k2", 16'(out_k), 16'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(out_valid), 16'd0);
    chk("arst_in_ready", 16'(in_ready), 16'd1);
    chk("arst_idx", 16'(lut_idx), 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 16'(out_valid), 16'd0);
    chk("post_rst_in_ready", 16'(in_ready), 16'd1);
    pulse(6'd5);
    tick();
    chk("restart_k", 16'(out_k), 16'd1);
    chk("restart_sin", out_logsin, 16'hA505);
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
